// File: rtl/dic_pkg.sv
// dic_pkg - shared definitions for the dual-issue controller.
//   state_e    : issue FSM encoding (PAIR = 1'b0, P2_ONLY = 1'b1)
//   AW_DEF     : default register index width
//   LD_LAT_DEF : default load-use latency in cycles
//   CW         : busy counter width (holds values up to 7)
package dic_pkg;

    localparam int AW_DEF     = 5;
    localparam int LD_LAT_DEF = 2;
    localparam int CW         = 3;

    typedef enum logic {
        PAIR    = 1'b0,
        P2_ONLY = 1'b1
    } state_e;

endpackage

// File: rtl/reg_busy_table.sv
// reg_busy_table - per-register load-busy scoreboard.
// Each register has a down-counter that is loaded when a load targeting it
// issues and counts down to zero; a non-zero counter marks the register busy.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clr_i                 clear every counter on the next posedge (beats sets)
//   set1_i / set1_rd_i    p1 issuing load and its destination
//   set2_i / set2_rd_i    p2 issuing load and its destination
//   look_rd_i[4]          lookup indices: p1 rs, p1 rt, p2 rs, p2 rt
//   busy_o[4]             busy flag for each lookup (r0 never busy)
module reg_busy_table
    import dic_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int LD_LAT = LD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                set1_i,
    input  logic [AW-1:0]       set1_rd_i,
    input  logic                set2_i,
    input  logic [AW-1:0]       set2_rd_i,
    input  logic [3:0][AW-1:0]  look_rd_i,
    output logic [3:0]          busy_o
);

    localparam int NREG = 2 ** AW;

    // The counter holds the number of cycles a consumer must still stall.
    // The cycle the load issues already counts as the first of LD_LAT, so a
    // consumer sees the register busy for LD_LAT-1 cycles and issues exactly
    // LD_LAT cycles after the load.
    localparam logic [CW-1:0] SET_VAL = CW'(LD_LAT - 1);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (clr_i) begin
                cnt_d[r] = '0;
            end else if ((set1_i && set1_rd_i == AW'(r)) ||
                         (set2_i && set2_rd_i == AW'(r))) begin
                // Both pipes load the same value, so the two sets just merge.
                cnt_d[r] = SET_VAL;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    // NOTE: this counter array is reset because it is control state (stale
    // busy bits after reset would stall the pipe); plain data RAMs are not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy_o[i] = (look_rd_i[i] != '0) && (cnt_q[look_rd_i[i]] != '0);
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl - ID-stage issue controller for a two-pipe datapath.
// Decides each cycle whether p1 (older), p2 (younger), both or neither issue,
// splits a pair over two cycles on intra-pair or load-use hazards, and
// arbitrates write-back so both pipes never write one register together.
// Optional feature: define DIC_FLUSH_EN to add the 'flush' input, which kills
// the current issue decision and returns the FSM and scoreboard to idle.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       (DIC_FLUSH_EN only) pipeline flush
//   pair_valid                  IF/ID holds a valid pair
//   pN_rs/pN_rt/pN_rd           pipe N source/destination registers
//   pN_wen, pN_load             pipe N writes rd / is a load
//   issue_p1, issue_p2          pipe leaves ID this cycle
//   fetch_hold                  IF/ID and PC must not advance
//   wb_wenN_i, wb_rdN_i         write-back request from pipe N
//   wb_wenN_o                   arbitrated register-file write enable N
module dual_issue_ctrl
    import dic_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int LD_LAT   = LD_LAT_DEF,
    parameter int DUAL_MEM = 0
) (
    input  logic          clk,
    input  logic          rst,
`ifdef DIC_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          pair_valid,
    input  logic [AW-1:0] p1_rs,
    input  logic [AW-1:0] p1_rt,
    input  logic [AW-1:0] p1_rd,
    input  logic          p1_wen,
    input  logic          p1_load,
    input  logic [AW-1:0] p2_rs,
    input  logic [AW-1:0] p2_rt,
    input  logic [AW-1:0] p2_rd,
    input  logic          p2_wen,
    input  logic          p2_load,
    output logic          issue_p1,
    output logic          issue_p2,
    output logic          fetch_hold,
    input  logic          wb_wen1_i,
    input  logic [AW-1:0] wb_rd1_i,
    input  logic          wb_wen2_i,
    input  logic [AW-1:0] wb_rd2_i,
    output logic          wb_wen1_o,
    output logic          wb_wen2_o
);

    state_e     state_q, state_d;
    logic       flush_w;
    logic [3:0] busy;
    logic       blk1, blk2, dep;

`ifdef DIC_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    reg_busy_table #(
        .AW     (AW),
        .LD_LAT (LD_LAT)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush_w),
        .set1_i    (issue_p1 && p1_load && (p1_rd != '0)),
        .set1_rd_i (p1_rd),
        .set2_i    (issue_p2 && p2_load && (p2_rd != '0)),
        .set2_rd_i (p2_rd),
        .look_rd_i ({p2_rt, p2_rs, p1_rt, p1_rs}),
        .busy_o    (busy)
    );

    assign blk1 = busy[0] | busy[1];
    assign blk2 = busy[2] | busy[3];

    // Intra-pair hazards: RAW on p1's result, load-after-load WAW (the later
    // load return must not be overtaken), and a shared memory port.
    assign dep = (p1_wen && (p1_rd != '0) && (p1_rd == p2_rs || p1_rd == p2_rt))
              || (p1_load && p2_wen && (p1_rd == p2_rd))
              || ((DUAL_MEM == 0) && p1_load && p2_load);

    // Issue decisions are combinational so a clean pair costs no extra cycle.
    // NOTE: every output gets a default first, so no path leaves a latch.
    always_comb begin
        issue_p1   = 1'b0;
        issue_p2   = 1'b0;
        fetch_hold = 1'b0;
        state_d    = state_q;
        if (flush_w) begin
            state_d = PAIR;
        end else if (!rst) begin
            case (state_q)
                PAIR: begin
                    if (pair_valid) begin
                        if (blk1) begin
                            // p2 never issues ahead of a stalled p1.
                            fetch_hold = 1'b1;
                        end else if (blk2 || dep) begin
                            issue_p1   = 1'b1;
                            fetch_hold = 1'b1;
                            state_d    = P2_ONLY;
                        end else begin
                            issue_p1 = 1'b1;
                            issue_p2 = 1'b1;
                        end
                    end
                end
                P2_ONLY: begin
                    if (blk2) begin
                        fetch_hold = 1'b1;
                    end else begin
                        issue_p2 = 1'b1;
                        state_d  = PAIR;
                    end
                end
                default: state_d = PAIR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PAIR;
        else     state_q <= state_d;
    end

    // Same-register write-back: the younger pipe's value is the architectural
    // result, so p1's write is dropped. r0 is not special-cased here.
    assign wb_wen1_o = !rst && wb_wen1_i && !(wb_wen2_i && (wb_rd1_i == wb_rd2_i));
    assign wb_wen2_o = !rst && wb_wen2_i;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Testbench for dual_issue_ctrl: two instances (single and dual memory port)
// share one directed stimulus stream; a scoreboard queue holds hand-computed
// expectations and a negedge monitor compares them.
module tb_dual_issue_ctrl;

    typedef struct packed {
        logic       rst;
        logic       pulse;
        logic       flush;
        logic       valid;
        logic [4:0] p1_rs, p1_rt, p1_rd;
        logic       p1_wen, p1_load;
        logic [4:0] p2_rs, p2_rt, p2_rd;
        logic       p2_wen, p2_load;
        logic       wb1, wb2;
        logic [4:0] wrd1, wrd2;
    } vec_t;

    typedef struct {
        logic [7:0] e;
        string      name;
    } exp_t;

    logic       clk, rst, flush, pair_valid;
    logic [4:0] p1_rs, p1_rt, p1_rd, p2_rs, p2_rt, p2_rd;
    logic       p1_wen, p1_load, p2_wen, p2_load;
    logic       wb_wen1_i, wb_wen2_i;
    logic [4:0] wb_rd1_i, wb_rd2_i;
    logic       issue_p1, issue_p2, fetch_hold, wb_wen1_o, wb_wen2_o;
    logic       dm_ip1, dm_ip2, dm_hold, dm_wb1, dm_wb2;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    dual_issue_ctrl #(.AW(5), .LD_LAT(2), .DUAL_MEM(0)) dut (
        .clk(clk), .rst(rst),
`ifdef DIC_FLUSH_EN
        .flush(flush),
`endif
        .pair_valid(pair_valid),
        .p1_rs(p1_rs), .p1_rt(p1_rt), .p1_rd(p1_rd), .p1_wen(p1_wen), .p1_load(p1_load),
        .p2_rs(p2_rs), .p2_rt(p2_rt), .p2_rd(p2_rd), .p2_wen(p2_wen), .p2_load(p2_load),
        .issue_p1(issue_p1), .issue_p2(issue_p2), .fetch_hold(fetch_hold),
        .wb_wen1_i(wb_wen1_i), .wb_rd1_i(wb_rd1_i), .wb_wen2_i(wb_wen2_i), .wb_rd2_i(wb_rd2_i),
        .wb_wen1_o(wb_wen1_o), .wb_wen2_o(wb_wen2_o)
    );

    dual_issue_ctrl #(.AW(5), .LD_LAT(2), .DUAL_MEM(1)) dut_dm (
        .clk(clk), .rst(rst),
`ifdef DIC_FLUSH_EN
        .flush(flush),
`endif
        .pair_valid(pair_valid),
        .p1_rs(p1_rs), .p1_rt(p1_rt), .p1_rd(p1_rd), .p1_wen(p1_wen), .p1_load(p1_load),
        .p2_rs(p2_rs), .p2_rt(p2_rt), .p2_rd(p2_rd), .p2_wen(p2_wen), .p2_load(p2_load),
        .issue_p1(dm_ip1), .issue_p2(dm_ip2), .fetch_hold(dm_hold),
        .wb_wen1_i(wb_wen1_i), .wb_rd1_i(wb_rd1_i), .wb_wen2_i(wb_wen2_i), .wb_rd2_i(wb_rd2_i),
        .wb_wen1_o(dm_wb1), .wb_wen2_o(dm_wb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid pair: srcs, dst, wen, load for p1 then p2.
    function automatic vec_t pv(input logic [4:0] a1, b1, d1, input logic w1, l1,
                                input logic [4:0] a2, b2, d2, input logic w2, l2);
        vec_t v;
        v = '0;
        v.valid = 1'b1;
        v.p1_rs = a1; v.p1_rt = b1; v.p1_rd = d1; v.p1_wen = w1; v.p1_load = l1;
        v.p2_rs = a2; v.p2_rt = b2; v.p2_rd = d2; v.p2_wen = w2; v.p2_load = l2;
        return v;
    endfunction

    function automatic vec_t wb(input vec_t vi, input logic w1, input logic [4:0] r1,
                                input logic w2, input logic [4:0] r2);
        vec_t v;
        v = vi;
        v.wb1 = w1; v.wrd1 = r1; v.wb2 = w2; v.wrd2 = r2;
        return v;
    endfunction

    // Drive one cycle of inputs and queue the expected
    // {issue_p1, issue_p2, hold, dm_issue_p1, dm_issue_p2, dm_hold, wb1_o, wb2_o}.
    task automatic step(input vec_t v, input logic [7:0] e, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = v.rst;
        flush      = v.flush;
        pair_valid = v.valid;
        p1_rs = v.p1_rs; p1_rt = v.p1_rt; p1_rd = v.p1_rd; p1_wen = v.p1_wen; p1_load = v.p1_load;
        p2_rs = v.p2_rs; p2_rt = v.p2_rt; p2_rd = v.p2_rd; p2_wen = v.p2_wen; p2_load = v.p2_load;
        wb_wen1_i = v.wb1; wb_rd1_i = v.wrd1; wb_wen2_i = v.wb2; wb_rd2_i = v.wrd2;
        if (v.pulse) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
        end
        x.e    = e;
        x.name = name;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle; compare at negedge.
    exp_t       mon_x;
    logic [7:0] mon_act;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_x   = exp_q.pop_front();
            mon_act = {issue_p1, issue_p2, fetch_hold, dm_ip1, dm_ip2, dm_hold, wb_wen1_o, wb_wen2_o};
            tests++;
            if (mon_act !== mon_x.e) begin
                fails++;
                $display("FAIL %s: got %b expected %b", mon_x.name, mon_act, mon_x.e);
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1'b1; flush = 1'b0; pair_valid = 1'b0;
        p1_rs = '0; p1_rt = '0; p1_rd = '0; p1_wen = 1'b0; p1_load = 1'b0;
        p2_rs = '0; p2_rt = '0; p2_rd = '0; p2_wen = 1'b0; p2_load = 1'b0;
        wb_wen1_i = 1'b0; wb_wen2_i = 1'b0; wb_rd1_i = '0; wb_rd2_i = '0;

        v = wb(pv(1, 2, 3, 1, 0, 4, 5, 6, 1, 0), 1, 7, 1, 7); v.rst = 1'b1;
        step(v, 8'b000_000_00, "rst_hold");
        step('0, 8'b000_000_00, "idle");
        step(wb(pv(1, 2, 3, 1, 0, 4, 5, 6, 1, 0), 1, 7, 1, 7), 8'b110_110_01, "indep_wb_conflict");
        step(wb(pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0), 1, 8, 1, 9), 8'b101_101_11, "raw_c0");
        step(wb(pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0), 1, 7, 0, 0), 8'b010_010_10, "raw_c1");
        step(wb(pv(1, 0, 5, 1, 1, 9, 10, 8, 1, 0), 1, 7, 0, 7), 8'b110_110_10, "load_t");
        step(pv(5, 1, 11, 1, 0, 2, 3, 12, 1, 0), 8'b001_001_00, "load_use_t1");
        step(pv(5, 1, 11, 1, 0, 2, 3, 12, 1, 0), 8'b110_110_00, "load_use_t2");
        step(pv(1, 0, 13, 1, 1, 2, 0, 14, 1, 1), 8'b101_110_00, "load_pair_c0");
        step(pv(1, 0, 13, 1, 1, 2, 0, 14, 1, 1), 8'b010_110_00, "load_pair_c1");
        step('0, 8'b000_000_00, "idle2");
        step(pv(1, 0, 15, 1, 1, 2, 3, 15, 1, 0), 8'b101_101_00, "load_waw_c0");
        step(pv(1, 0, 15, 1, 1, 2, 3, 15, 1, 0), 8'b010_010_00, "load_waw_c1");
        step(pv(1, 0, 16, 1, 1, 0, 0, 0, 0, 0), 8'b110_110_00, "blk1_load");
        step(pv(16, 1, 17, 1, 0, 0, 0, 0, 0, 0), 8'b001_001_00, "blk1_stall");
        step(pv(16, 1, 17, 1, 0, 0, 0, 0, 0, 0), 8'b110_110_00, "blk1_go");
        step(pv(1, 0, 18, 1, 1, 18, 0, 19, 1, 0), 8'b101_101_00, "blk2_c0");
        step(pv(1, 0, 18, 1, 1, 18, 0, 19, 1, 0), 8'b001_001_00, "blk2_stall");
        step(pv(1, 0, 18, 1, 1, 18, 0, 19, 1, 0), 8'b010_010_00, "blk2_go");
        step(pv(1, 2, 0, 1, 0, 0, 0, 20, 1, 0), 8'b110_110_00, "r0_dest");
        step(pv(1, 0, 0, 1, 1, 0, 0, 20, 1, 0), 8'b110_110_00, "r0_load");
        step(pv(0, 0, 21, 1, 0, 0, 0, 0, 0, 0), 8'b110_110_00, "r0_never_busy");
        step(pv(1, 0, 21, 1, 1, 21, 0, 22, 1, 0), 8'b101_101_00, "rst_setup");
        v = pv(21, 1, 23, 1, 0, 0, 0, 0, 0, 0); v.pulse = 1'b1;
        step(v, 8'b110_110_00, "rst_pulse_clears");
        v = wb(pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0), 1, 7, 1, 7); v.rst = 1'b1;
        step(v, 8'b000_000_00, "rst_full");
        step(pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0), 8'b101_101_00, "after_rst");
`ifdef DIC_FLUSH_EN
        v = pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0); v.flush = 1'b1;
        step(v, 8'b000_000_00, "flush_p2_only");
        step(pv(1, 2, 3, 1, 0, 3, 4, 7, 1, 0), 8'b101_101_00, "post_flush");
`endif

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
